muxn_pipe: RTL and testbench
============================

// Module: muxn_pipe
// PURPOSE
//  Parametrised N-way data select with a registered, valid/ready-handshaked output stage.
//  Successor to the fixed 3-way select used for the ALU operand and forwarding paths.
//  Out-of-range select codes are defined: output 0 plus an error flag, never alias to a legal input.
//  Sits between the pipeline-register outputs and the downstream consumer. Sustains 1 beat/cycle under backpressure.
// PARAMETERS
//  WIDTH   32  data width of each input and of y
//  NUM_IN  3   number of inputs, 2..16; SEL_W = $clog2(NUM_IN) (localparam)
// PORTS
//  clk        in   1             rising-edge clock; single clock domain
//  reset      in   1             synchronous, active-high
//  in_valid   in   1             upstream beat valid
//  in_ready   out  1             block can accept a beat this cycle
//  sel        in   SEL_W         input index, sampled with the beat
//  data       in   NUM_IN*WIDTH  packed inputs; input i = data[i*WIDTH +: WIDTH]
//  out_valid  out  1             y/sel_err valid
//  out_ready  in   1             downstream accepts
//  y          out  WIDTH         selected data
//  sel_err    out  1             beat on y came from an illegal sel (sel >= NUM_IN)
//  err_sticky out  1             set by any accepted illegal beat; cleared only by reset
// BEHAVIOUR
//  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
//  - Storage: 2-entry skid buffer (main reg + skid reg). Fill states are EMPTY, ONE and TWO.
//    - in_ready = (state != TWO). It is a registered signal and has no combinational path from out_ready.
//    - out_valid = (state != EMPTY). y/sel_err are always driven from the main reg.
//  - State transitions:
//    - EMPTY --accept--> ONE
//    - ONE   --accept & !deliver--> TWO
//    - ONE   --deliver & !accept--> EMPTY
//    - ONE   --accept & deliver--> ONE (main reg reloads with the new beat)
//    - TWO   --deliver--> ONE (skid moves to main). No accept is possible in TWO.
//  - Latency: an accepted beat appears on y at the next rising edge when the buffer was EMPTY.
//  - Ordering is strictly FIFO. No beat is dropped or duplicated.
//  - While out_valid & !out_ready, y and sel_err hold stable.
//  - Select: sel < NUM_IN gives y = input[sel] and sel_err = 0. sel >= NUM_IN gives y = 0 and sel_err = 1.
//  - When NUM_IN is a power of two, illegal codes cannot occur and sel_err stays 0.
//  - err_sticky is set in the cycle after an illegal beat is accepted. Non-accepted illegal sel values do not set it.
//  - Reset (any cycle, including mid-transfer): state = EMPTY, in_ready = 1, out_valid = 0, y = 0,
//    sel_err = 0, err_sticky = 0. Buffered beats are discarded.
// CONFIGURATION
//  - MUXN_ERR_CNT_EN defined: adds output err_cnt [15:0], which counts accepted illegal beats,
//    saturates at 16'hFFFF, and resets to 0.
//  - MUXN_ERR_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package muxn_pkg: fill-state encoding (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2) and
//    the constant ERR_CNT_W = 16.
//  - Sub-module muxn_comb: purely combinational N-way select with illegal-code detect
//    (params WIDTH, NUM_IN; ports sel, data, y, illegal).
//  - muxn_pipe instantiates one muxn_comb on the input side. It adds the skid buffer, the FSM and the error logic.
// TESTING
//  1. Reset, then NUM_IN=3, WIDTH=32, inputs A/B/C, sel=0,1,2, out_ready=1 ->
//     y=A,B,C on consecutive cycles, 1-cycle latency, sel_err=0.
//  2. sel=2'b11 with NUM_IN=3 -> y=32'h0, sel_err=1, err_sticky=1 next cycle.
//     The illegal sel must not alias to input B.
//  3. Stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts, y holds beat 0.
//     Raise out_ready -> beats 0..3 in order, none lost.
//  4. Continuous in_valid with out_ready toggling 1/0 -> accepted beat count equals delivered count,
//     and order is preserved.
//  5. Reset asserted while state=TWO -> next cycle out_valid=0, in_ready=1, err_sticky=0, y=0.
//  6. With MUXN_ERR_CNT_EN and 3 illegal accepted beats -> err_cnt=3.
//     Force 65537 illegal beats -> err_cnt=16'hFFFF.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_pipe select stage: skid-buffer fill states
// and the width of the optional illegal-beat counter.
package muxn_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fill_state_e;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/muxn_comb.sv
// Purely combinational N-way select. Codes at or above NUM_IN yield zero data
// and raise illegal, so they can never alias onto a legal input.
module muxn_comb
  import muxn_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        y,
  output logic                    illegal
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  always_comb begin
    y       = '0;
    illegal = ({1'b0, sel} >= NUM_IN_W);
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        y = data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way select feeding a 2-entry skid buffer with a valid/ready output stage.
// Defining MUXN_ERR_CNT_EN adds err_cnt, a saturating count of accepted illegal beats.
//
// Handshake: a beat moves when valid & ready are both high at a rising edge;
// a producer holds valid and its payload until that edge, and in_ready is
// a flop so it never depends combinationally on out_ready.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    sel_err,
  output logic                    err_sticky,
  output fill_state_e             dbg_state
`ifdef MUXN_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

  logic [WIDTH-1:0] sel_y;
  logic             sel_illegal;

  muxn_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_comb (
    .sel     (sel),
    .data    (data),
    .y       (sel_y),
    .illegal (sel_illegal)
  );

  fill_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             accept, deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    err_sticky_d = err_sticky_q | (accept & sel_illegal);
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = sel_y;
          main_err_d  = sel_illegal;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          skid_data_d = sel_y;
          skid_err_d  = sel_illegal;
          state_d     = TWO;
        end else if (accept && deliver) begin
          main_data_d = sel_y;
          main_err_d  = sel_illegal;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path exists
        if (deliver) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef MUXN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && sel_illegal && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign y          = main_data_q;
  assign sel_err    = main_err_q;
  assign err_sticky = err_sticky_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: random beats, expected results queued on accept from a
// select reference model, compared by an independent output monitor.
module tb_muxn_pipe;
  import muxn_pkg::*;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = $clog2(NUM_IN);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel = '0;
  logic [NUM_IN*WIDTH-1:0] data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [WIDTH-1:0]        y;
  logic                    sel_err;
  logic                    err_sticky;
  fill_state_e             dbg_state;
`ifdef MUXN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0]    err_cnt;
`endif

  muxn_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .data       (data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .sel_err    (sel_err),
    .err_sticky (err_sticky),
    .dbg_state  (dbg_state)
`ifdef MUXN_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_exp;
  int n_accept = 0;
  int n_deliver = 0;
  int ready_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference select: legal code picks that word, anything else is zero plus error.
  function automatic logic [WIDTH:0] ref_beat(input int s, input logic [WIDTH-1:0] w[NUM_IN]);
    if (s < NUM_IN) return {1'b0, w[s]};
    return {1'b1, {WIDTH{1'b0}}};
  endfunction

  // out_ready pattern: 0 low, 1 high, 2 toggle, other random
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input int s);
    logic [WIDTH-1:0] w[NUM_IN];
    bit got;
    got = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      w[i] = $urandom();
      data[i*WIDTH +: WIDTH] = w[i];
    end
    sel      = SEL_W'(s);
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        last_exp = ref_beat(s, w);
        exp_q.push_back(last_exp);
        n_accept++;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_drain();
    ready_mode = 1;
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_mode_settle(input int m);
    ready_mode = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic           stall_prev = 1'b0;
  logic [WIDTH:0] held;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) check("hold_stable", 64'({sel_err, y}), 64'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          check("beat", 64'({sel_err, y}), 64'(exp_q.pop_front()));
          n_deliver++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {sel_err, y};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [WIDTH:0] beat0;
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_sel_err", 64'(sel_err), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(EMPTY));

    // legal selects, one-cycle latency, back to back
    set_mode_settle(1);
    for (int s = 0; s < NUM_IN; s++) begin
      drive_beat(s);
      check("latency_valid", 64'(out_valid), 64'd1);
      check("latency_y", 64'({sel_err, y}), 64'(last_exp));
    end
    wait_drain();
    check("sticky_clear", 64'(err_sticky), 64'd0);

    // illegal select: zero data, error flag, sticky next cycle
    drive_beat(3);
    check("illegal_y", 64'({sel_err, y}), 64'({1'b1, {WIDTH{1'b0}}}));
    check("illegal_sticky", 64'(err_sticky), 64'd1);
    wait_drain();

    // backpressure: two accepts fill the buffer, then stall
    set_mode_settle(0);
    drive_beat($urandom_range(0, NUM_IN - 1));
    beat0 = last_exp;
    drive_beat($urandom_range(0, NUM_IN - 1));
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_state", 64'(dbg_state), 64'(TWO));
    check("full_y", 64'({sel_err, y}), 64'(beat0));
    fork
      begin
        drive_beat($urandom_range(0, NUM_IN - 1));
        drive_beat($urandom_range(0, NUM_IN - 1));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_y", 64'({sel_err, y}), 64'(beat0));
        ready_mode = 1;
      end
    join
    wait_drain();
    check("bp_counts", 64'(n_deliver), 64'(n_accept));

    // continuous traffic with toggling then random out_ready
    set_mode_settle(2);
    for (int i = 0; i < 40; i++) drive_beat($urandom_range(0, 3));
    ready_mode = 3;
    for (int i = 0; i < 40; i++) drive_beat($urandom_range(0, 3));
    wait_drain();
    check("stream_counts", 64'(n_deliver), 64'(n_accept));

    // reset while full
    set_mode_settle(0);
    drive_beat(3);
    drive_beat(1);
    check("pre_rst_state", 64'(dbg_state), 64'(TWO));
    check("pre_rst_sticky", 64'(err_sticky), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_accept  = 0;
    n_deliver = 0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sticky", 64'(err_sticky), 64'd0);
    check("mid_rst_y", 64'({sel_err, y}), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(EMPTY));

`ifdef MUXN_ERR_CNT_EN
    set_mode_settle(1);
    for (int i = 0; i < 3; i++) drive_beat(NUM_IN);
    check("err_cnt_3", 64'(err_cnt), 64'd3);
    for (int i = 3; i < 65537; i++) drive_beat(NUM_IN);
    check("err_cnt_sat", 64'(err_cnt), 64'hFFFF);
`endif

    wait_drain();
    check("final_counts", 64'(n_deliver), 64'(n_accept));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
